// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between result producers and the register file port.
// Forwarding lookup signals are present only when WB_FWD_EN is defined.
interface regfile_wb_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              reg_write;
  logic [ADDR_W-1:0] w_reg0;
  logic [DATA_W-1:0] w_data;
  logic [CW-1:0]     fifo_count;
`ifdef WB_FWD_EN
  logic [ADDR_W-1:0] fwd_reg0;
  logic [ADDR_W-1:0] fwd_reg1;
  logic              fwd_hit0;
  logic              fwd_hit1;
  logic [DATA_W-1:0] fwd_data0;
  logic [DATA_W-1:0] fwd_data1;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output fwd_reg0, fwd_reg1,
    input  alu_ready, mem_ready,
    input  reg_write, w_reg0, w_data,
    input  fifo_count,
    input  fwd_hit0, fwd_hit1,
    input  fwd_data0, fwd_data1
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  fwd_reg0, fwd_reg1,
    output alu_ready, mem_ready,
    output reg_write, w_reg0, w_data,
    output fifo_count,
    output fwd_hit0, fwd_hit1,
    output fwd_data0, fwd_data1
  );
`else
  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready,
    input  reg_write, w_reg0, w_data,
    input  fifo_count
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready,
    output reg_write, w_reg0, w_data,
    output fifo_count
  );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: buffered ALU stream vs. prioritised loads.
// Optional WB_FWD_EN adds combinational forwarding lookups over in-flight values.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_LIM = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

  logic [ADDR_W-1:0] r_qreg [DEPTH];
  logic [DATA_W-1:0] r_qdat [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [SW-1:0]     r_starve;
  logic              r_we;
  logic [ADDR_W-1:0] r_wsel;
  logic [DATA_W-1:0] r_wdat;

  logic              w_force;
  logic              w_alu_acc;
  logic              w_mem_acc;
  logic              w_alu_nz;
  logic              w_mem_nz;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_cut;
  logic              w_we_n;
  logic [ADDR_W-1:0] w_sel_n;
  logic [DATA_W-1:0] w_dat_n;
  logic [SW-1:0]     w_starve_n;

  assign w_empty   = (r_count == '0);
  assign w_force   = (r_starve == SW'(STARVE_LIM)) && !w_empty;
  assign w_alu_nz  = (bus.alu_reg != '0);
  assign w_mem_nz  = (bus.mem_reg != '0);

  assign bus.alu_ready = (r_count < CW'(DEPTH));
  assign bus.mem_ready = !w_force;

  assign w_alu_acc = bus.alu_valid && bus.alu_ready;
  assign w_mem_acc = bus.mem_valid && bus.mem_ready;

  always_comb begin
    w_pop      = 1'b0;
    w_cut      = 1'b0;
    w_we_n     = 1'b0;
    w_sel_n    = r_wsel;
    w_dat_n    = r_wdat;
    w_starve_n = r_starve;
    if (w_force) begin
      w_pop      = 1'b1;
      w_we_n     = 1'b1;
      w_sel_n    = r_qreg[r_rptr];
      w_dat_n    = r_qdat[r_rptr];
      w_starve_n = '0;
    end else if (w_mem_acc) begin
      // A register-0 load still burns a slot for starvation accounting
      w_we_n = w_mem_nz;
      if (w_mem_nz) begin
        w_sel_n = bus.mem_reg;
        w_dat_n = bus.mem_data;
      end
      if (w_empty)
        w_starve_n = '0;
      else if (r_starve != SW'(STARVE_LIM))
        w_starve_n = r_starve + 1'b1;
    end else if (!w_empty) begin
      w_pop      = 1'b1;
      w_we_n     = 1'b1;
      w_sel_n    = r_qreg[r_rptr];
      w_dat_n    = r_qdat[r_rptr];
      w_starve_n = '0;
    end else if (w_alu_acc && w_alu_nz) begin
      w_cut   = 1'b1;
      w_we_n  = 1'b1;
      w_sel_n = bus.alu_reg;
      w_dat_n = bus.alu_data;
    end
  end

  assign w_push = w_alu_acc && w_alu_nz && !w_cut;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_we     <= 1'b0;
      r_wsel   <= '0;
      r_wdat   <= '0;
    end else if (flush) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_we     <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      r_starve <= w_starve_n;
      r_we     <= w_we_n;
      r_wsel   <= w_sel_n;
      r_wdat   <= w_dat_n;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by r_count
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_qreg[r_wptr] <= bus.alu_reg;
      r_qdat[r_wptr] <= bus.alu_data;
    end
  end

  assign bus.reg_write  = r_we;
  assign bus.w_reg0     = r_wsel;
  assign bus.w_data     = r_wdat;
  assign bus.fifo_count = r_count;

`ifdef WB_FWD_EN
  logic [ADDR_W-1:0] w_freg [2];
  logic              w_fhit [2];
  logic [DATA_W-1:0] w_fdat [2];

  assign w_freg[0] = bus.fwd_reg0;
  assign w_freg[1] = bus.fwd_reg1;

  // Scan oldest to youngest so later matches win, then the output stage
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_fhit[j] = 1'b0;
      w_fdat[j] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < r_count) &&
            (r_qreg[r_rptr + PW'(i)] == w_freg[j])) begin
          w_fhit[j] = 1'b1;
          w_fdat[j] = r_qdat[r_rptr + PW'(i)];
        end
      end
      if (r_we && (r_wsel == w_freg[j])) begin
        w_fhit[j] = 1'b1;
        w_fdat[j] = r_wdat;
      end
      if (w_freg[j] == '0) begin
        w_fhit[j] = 1'b0;
        w_fdat[j] = '0;
      end
    end
  end

  assign bus.fwd_hit0  = w_fhit[0];
  assign bus.fwd_hit1  = w_fhit[1];
  assign bus.fwd_data0 = w_fdat[0];
  assign bus.fwd_data1 = w_fdat[1];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
// Forwarding checks are compiled only when WB_FWD_EN is defined.
module tb_regfile_wb_arbiter;
  logic clk;
  logic reset;
  logic flush;
  int   vectors;
  int   miscompares;

  regfile_wb_arbiter_if #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wb_arbiter #(
    .DEPTH(4), .DATA_W(32), .ADDR_W(5), .STARVE_LIM(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input string tag, input logic we,
                    input logic [4:0] r, input logic [31:0] d,
                    input logic [2:0] cnt);
    chk({tag, ".we"}, 64'(bus.reg_write), 64'(we));
    chk({tag, ".reg"}, 64'(bus.w_reg0), 64'(r));
    chk({tag, ".data"}, 64'(bus.w_data), 64'(d));
    chk({tag, ".cnt"}, 64'(bus.fifo_count), 64'(cnt));
  endtask

  task automatic idle_in();
    bus.alu_valid = 1'b0;
    bus.alu_reg   = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_reg   = '0;
    bus.mem_data  = '0;
  endtask

  logic [36:0] q[$];
  logic [36:0] e;
  int          sent;
  int          got;
  logic        acc;
  logic        saw_full;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    flush       = 1'b0;
    idle_in();
`ifdef WB_FWD_EN
    bus.fwd_reg0 = '0;
    bus.fwd_reg1 = '0;
`endif
    #3;
    wr("reset", 1'b0, 5'd0, 32'h0, 3'd0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst.alu_ready", 64'(bus.alu_ready), 64'd1);
    chk("rst.mem_ready", 64'(bus.mem_ready), 64'd1);

    bus.alu_valid = 1'b1;
    bus.alu_reg   = 5'd5;
    bus.alu_data  = 32'h1234;
    tick();
    idle_in();
    wr("cut", 1'b1, 5'd5, 32'h1234, 3'd0);
    tick();
    wr("cut.idle", 1'b0, 5'd5, 32'h1234, 3'd0);

    bus.mem_valid = 1'b1;
    bus.mem_reg   = 5'd3;
    bus.mem_data  = 32'hAAAA;
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 5'd4;
    bus.alu_data  = 32'hBBBB;
    tick();
    idle_in();
    wr("both.ld", 1'b1, 5'd3, 32'hAAAA, 3'd1);
    tick();
    wr("both.alu", 1'b1, 5'd4, 32'hBBBB, 3'd0);
    tick();
    wr("both.idle", 1'b0, 5'd4, 32'hBBBB, 3'd0);

    bus.mem_valid = 1'b1;
    bus.mem_reg   = 5'd10;
    bus.mem_data  = 32'h100;
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 5'd11;
    bus.alu_data  = 32'h11;
    tick();
    wr("stv.a", 1'b1, 5'd10, 32'h100, 3'd1);
    bus.alu_reg  = 5'd12;
    bus.alu_data = 32'h12;
    bus.mem_data = 32'h101;
    tick();
    wr("stv.b", 1'b1, 5'd10, 32'h101, 3'd2);
    bus.alu_valid = 1'b0;
    bus.mem_data  = 32'h102;
    tick();
    wr("stv.c", 1'b1, 5'd10, 32'h102, 3'd2);
    chk("stv.c.mrdy", 64'(bus.mem_ready), 64'd1);
    bus.mem_data = 32'h103;
    tick();
    wr("stv.d", 1'b1, 5'd10, 32'h103, 3'd2);
    chk("stv.d.mrdy", 64'(bus.mem_ready), 64'd0);
    bus.mem_data = 32'h104;
    tick();
    wr("stv.force", 1'b1, 5'd11, 32'h11, 3'd1);
    chk("stv.e.mrdy", 64'(bus.mem_ready), 64'd1);
    tick();
    wr("stv.resume", 1'b1, 5'd10, 32'h104, 3'd1);
    bus.mem_valid = 1'b0;
    tick();
    wr("stv.drain", 1'b1, 5'd12, 32'h12, 3'd0);
    tick();
    wr("stv.idle", 1'b0, 5'd12, 32'h12, 3'd0);

    bus.mem_valid = 1'b1;
    bus.mem_reg   = 5'd20;
    bus.mem_data  = 32'h200;
    sent     = 0;
    got      = 0;
    saw_full = 1'b0;
    for (int c = 0; c < 100 && got < 6; c++) begin
      bus.alu_valid = (sent < 6);
      bus.alu_reg   = 5'(21 + sent);
      bus.alu_data  = 32'(32'h301 + sent);
      if (bus.fifo_count == 3'd4) begin
        saw_full = 1'b1;
        chk("burst.full_rdy", 64'(bus.alu_ready), 64'd0);
      end
      acc = bus.alu_valid && bus.alu_ready;
      if (acc)
        q.push_back({bus.alu_reg, bus.alu_data});
      tick();
      if (acc)
        sent++;
      if (bus.reg_write && bus.w_reg0 == 5'd20) begin
        chk("burst.ld", 64'(bus.w_data), 64'h200);
      end else if (bus.reg_write) begin
        if (q.size() == 0) begin
          chk("burst.extra", 64'(bus.w_reg0), 64'd0);
        end else begin
          e = q.pop_front();
          chk("burst.alu", 64'({bus.w_reg0, bus.w_data}), 64'(e));
          got++;
        end
      end
    end
    chk("burst.sawfull", 64'(saw_full), 64'd1);
    chk("burst.got", 64'(got), 64'd6);
    chk("burst.cnt", 64'(bus.fifo_count), 64'd0);
    idle_in();
    tick();
    tick();

    bus.alu_valid = 1'b1;
    bus.alu_reg   = 5'd0;
    bus.alu_data  = 32'hDEAD;
    bus.mem_valid = 1'b1;
    bus.mem_reg   = 5'd0;
    bus.mem_data  = 32'hBEEF;
    chk("r0.ardy", 64'(bus.alu_ready), 64'd1);
    chk("r0.mrdy", 64'(bus.mem_ready), 64'd1);
    tick();
    bus.mem_valid = 1'b0;
    chk("r0.both.we", 64'(bus.reg_write), 64'd0);
    chk("r0.both.cnt", 64'(bus.fifo_count), 64'd0);
    tick();
    idle_in();
    chk("r0.alu.we", 64'(bus.reg_write), 64'd0);
    chk("r0.alu.cnt", 64'(bus.fifo_count), 64'd0);

    bus.mem_valid = 1'b1;
    bus.mem_reg   = 5'd2;
    bus.mem_data  = 32'h22;
    bus.alu_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.alu_reg  = 5'(8 + k);
      bus.alu_data = 32'(32'h80 + k);
      tick();
    end
    chk("fl.pre.cnt", 64'(bus.fifo_count), 64'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle_in();
    chk("fl.we", 64'(bus.reg_write), 64'd0);
    chk("fl.cnt", 64'(bus.fifo_count), 64'd0);
    tick();
    chk("fl.post.we", 64'(bus.reg_write), 64'd0);
    chk("fl.post.cnt", 64'(bus.fifo_count), 64'd0);

    bus.mem_valid = 1'b1;
    bus.mem_reg   = 5'd6;
    bus.mem_data  = 32'h66;
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 5'd7;
    bus.alu_data  = 32'h77;
    tick();
    wr("mid.pre", 1'b1, 5'd6, 32'h66, 3'd1);
    #2;
    reset = 1'b1;
    #1;
    wr("mid.rst", 1'b0, 5'd0, 32'h0, 3'd0);
    idle_in();
    tick();
    reset = 1'b0;
    chk("mid.ardy", 64'(bus.alu_ready), 64'd1);
    tick();
    chk("mid.idle.we", 64'(bus.reg_write), 64'd0);

`ifdef WB_FWD_EN
    bus.mem_valid = 1'b1;
    bus.mem_reg   = 5'd2;
    bus.mem_data  = 32'h55;
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 5'd7;
    bus.alu_data  = 32'h1;
    tick();
    bus.alu_data = 32'h2;
    tick();
    idle_in();
    bus.fwd_reg0 = 5'd7;
    bus.fwd_reg1 = 5'd2;
    #1;
    chk("fwd.cnt", 64'(bus.fifo_count), 64'd2);
    chk("fwd.hit0", 64'(bus.fwd_hit0), 64'd1);
    chk("fwd.data0", 64'(bus.fwd_data0), 64'h2);
    chk("fwd.hit1", 64'(bus.fwd_hit1), 64'd1);
    chk("fwd.data1", 64'(bus.fwd_data1), 64'h55);
    bus.fwd_reg0 = 5'd0;
    bus.fwd_reg1 = 5'd9;
    #1;
    chk("fwd.r0.hit", 64'(bus.fwd_hit0), 64'd0);
    chk("fwd.r0.data", 64'(bus.fwd_data0), 64'd0);
    chk("fwd.miss.hit", 64'(bus.fwd_hit1), 64'd0);
    tick();
    tick();
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
